// File: rtl/prog_loader.sv
// Boot-time program loader: receives a word count plus a big-endian image over a byte stream,
// writes it into the core memory and raises start. Optional trailing XOR checksum: LOADER_CSUM_EN.
module prog_loader #(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              start,
  output logic              busy,
  output logic              error,
  output logic [15:0]       words_loaded
);

`ifdef LOADER_CSUM_EN
  typedef enum logic [2:0] {HDR_HI, HDR_LO, PAYLOAD, WRITE, DONE, ERROR, CSUM} state_t;
  localparam state_t LOAD_END = CSUM;
`else
  typedef enum logic [2:0] {HDR_HI, HDR_LO, PAYLOAD, WRITE, DONE, ERROR} state_t;
  localparam state_t LOAD_END = DONE;
`endif

  state_t            state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [23:0]       asm_q, asm_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [15:0]       words_q, words_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rdy;
`ifdef LOADER_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HDR_HI;
      n_q     <= '0;
      asm_q   <= '0;
      bidx_q  <= '0;
      words_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef LOADER_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      asm_q   <= asm_d;
      bidx_q  <= bidx_d;
      words_q <= words_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef LOADER_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    asm_d   = asm_q;
    bidx_d  = bidx_q;
    words_d = words_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdy     = 1'b0;
`ifdef LOADER_CSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      HDR_HI: begin
        rdy = 1'b1;
        if (in_valid) begin
          n_d[15:8] = in_data;
          state_d   = HDR_LO;
        end
      end
      HDR_LO: begin
        rdy = 1'b1;
        if (in_valid) begin
          n_d[7:0] = in_data;
          if (32'(n_d) > MAX_WORDS)  state_d = ERROR;
          else if (n_d == 16'd0)     state_d = LOAD_END;
          else                       state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        rdy = 1'b1;
        if (in_valid) begin
          bidx_d = bidx_q + 2'd1;
          asm_d  = {asm_q[15:0], in_data};
          // Address and data are captured here so they stay valid (and held) after WRITE.
          if (bidx_q == 2'd3) begin
            addr_d  = ADDR_W'(BASE_ADDR + 32'(words_q));
            wdata_d = {asm_q, in_data};
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        words_d = words_q + 16'd1;
        state_d = (words_d == n_q) ? LOAD_END : PAYLOAD;
      end
`ifdef LOADER_CSUM_EN
      CSUM: begin
        rdy = 1'b1;
        if (in_valid) state_d = (in_data == csum_q) ? DONE : ERROR;
      end
`endif
      DONE:    state_d = DONE;
      ERROR:   state_d = ERROR;
      default: state_d = HDR_HI;
    endcase
`ifdef LOADER_CSUM_EN
    if (rdy && in_valid) csum_d = csum_q ^ in_data;
`endif
  end

  // Gated so the reset-state ready does not leak out while rst_n is held low.
  assign in_ready     = rdy & rst_n;
  assign mem_we       = (state_q == WRITE);
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign start        = (state_q == DONE);
  assign error        = (state_q == ERROR);
  assign words_loaded = words_q;
`ifdef LOADER_CSUM_EN
  assign busy = (state_q == PAYLOAD) || (state_q == WRITE) || (state_q == CSUM);
`else
  assign busy = (state_q == PAYLOAD) || (state_q == WRITE);
`endif

endmodule
